// File: rtl/ctrl_line_master.sv
// Half-duplex serial master for one transceiver channel: frames command bytes out on ctrl_d,
// turns the bus around and receives response bytes. CTRL_LINE_RX_MAJORITY_EN enables 2-of-3 bit voting.
module ctrl_line_master #(
    parameter int G_BIT_CYCLES  = 4,
    parameter int G_TURN_CYCLES = 8,
    parameter int G_TIMEOUT     = 1023
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    input  logic [3:0] rx_expect,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       timeout,
    output logic       busy,
    output logic       ctrl_d,
    output logic       ctrl_de,
    output logic       ctrl_ren,
    input  logic       ctrl_r
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_TX      = 3'd1;
    localparam logic [2:0] S_TX_HOLD = 3'd2;
    localparam logic [2:0] S_TURN_RX = 3'd3;
    localparam logic [2:0] S_RX_WAIT = 3'd4;
    localparam logic [2:0] S_RX      = 3'd5;
    localparam logic [2:0] S_TURN_TX = 3'd6;

    localparam int TURN_W = $clog2(G_TURN_CYCLES + 1);
    localparam int TOUT_W = $clog2(G_TIMEOUT + 1);
    localparam logic [7:0]        BIT_LAST  = 8'(G_BIT_CYCLES - 1);
    localparam logic [7:0]        MID       = 8'(G_BIT_CYCLES / 2);
    localparam logic [7:0]        MID_P1    = 8'(G_BIT_CYCLES / 2 + 1);
    localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(G_TURN_CYCLES - 1);
    localparam logic [TURN_W-1:0] TURN_ONE  = TURN_W'(1);
    localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(G_TIMEOUT - 1);
    localparam logic [TOUT_W-1:0] TOUT_ONE  = TOUT_W'(1);
`ifdef CTRL_LINE_RX_MAJORITY_EN
    localparam logic [7:0]        MID_M1    = 8'(G_BIT_CYCLES / 2 - 1);
`endif

    logic [2:0]        state_r;
    logic [7:0]        tx_shreg_r;
    logic [3:0]        tx_bit_r;     // 10 marks the final stop-bit cycle on the line
    logic [7:0]        tx_cyc_r;
    logic              last_r;
    logic [3:0]        rx_exp_r;
    logic [3:0]        rem_r;
    logic [TURN_W-1:0] turn_cnt_r;
    logic [TOUT_W-1:0] tout_cnt_r;
    logic [3:0]        rx_bit_r;
    logic [7:0]        rx_cyc_r;
    logic [7:0]        rx_shreg_r;
    logic              s_mid_r;
`ifdef CTRL_LINE_RX_MAJORITY_EN
    logic              s_m1_r;
`endif
    logic              sync1_r;
    logic              sync2_r;
    logic              tx_ready_r;
    logic              ctrl_d_r;
    logic              ctrl_de_r;
    logic              ctrl_ren_r;
    logic              busy_r;
    logic [7:0]        rx_data_r;
    logic              rx_valid_r;
    logic              rx_err_r;
    logic              timeout_r;
    logic              accept_s;
    logic              rx_vote_s;

    function automatic logic frame_bit(input logic [3:0] idx, input logic data_lsb);
        logic b;
        if (idx == 4'd0) begin
            b = 1'b0;
        end else if (idx <= 4'd8) begin
            b = data_lsb;
        end else begin
            b = 1'b1;
        end
        return b;
    endfunction

    assign accept_s = tx_valid & tx_ready_r;

    // Received bit decision, resolved in the mid+1 cycle of each bit
    always_comb begin
        rx_vote_s = 1'b1;
`ifdef CTRL_LINE_RX_MAJORITY_EN
        rx_vote_s = (s_m1_r & s_mid_r) | (s_m1_r & sync2_r) | (s_mid_r & sync2_r);
`else
        rx_vote_s = s_mid_r;
`endif
    end

    // Two-flop synchroniser for the asynchronous receiver output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= ctrl_r;
            sync2_r <= sync1_r;
        end
    end

    // Main controller: state, counters and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            tx_shreg_r <= 8'd0;
            tx_bit_r   <= 4'd0;
            tx_cyc_r   <= 8'd0;
            last_r     <= 1'b0;
            rx_exp_r   <= 4'd0;
            rem_r      <= 4'd0;
            turn_cnt_r <= '0;
            tout_cnt_r <= '0;
            rx_bit_r   <= 4'd0;
            rx_cyc_r   <= 8'd0;
            rx_shreg_r <= 8'd0;
            s_mid_r    <= 1'b1;
`ifdef CTRL_LINE_RX_MAJORITY_EN
            s_m1_r     <= 1'b1;
`endif
            tx_ready_r <= 1'b0;
            ctrl_d_r   <= 1'b1;
            ctrl_de_r  <= 1'b1;
            ctrl_ren_r <= 1'b1;
            busy_r     <= 1'b0;
            rx_data_r  <= 8'd0;
            rx_valid_r <= 1'b0;
            rx_err_r   <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            rx_err_r   <= 1'b0;
            timeout_r  <= 1'b0;
            case (state_r)
                S_IDLE, S_TX_HOLD: begin
                    ctrl_d_r   <= 1'b1;
                    ctrl_de_r  <= 1'b1;
                    ctrl_ren_r <= 1'b1;
                    if (accept_s) begin
                        tx_shreg_r <= tx_data;
                        last_r     <= tx_last;
                        rx_exp_r   <= rx_expect;
                        tx_bit_r   <= 4'd0;
                        tx_cyc_r   <= 8'd0;
                        tx_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= S_TX;
                    end else begin
                        tx_ready_r <= 1'b1;
                        busy_r     <= (state_r != S_IDLE);
                    end
                end
                S_TX: begin
                    if (tx_bit_r == 4'd10) begin
                        if (!last_r && accept_s) begin
                            // Back-to-back: the next start bit follows with no gap
                            tx_shreg_r <= tx_data;
                            last_r     <= tx_last;
                            rx_exp_r   <= rx_expect;
                            ctrl_d_r   <= 1'b0;
                            tx_bit_r   <= 4'd0;
                            tx_cyc_r   <= 8'd1;
                            tx_ready_r <= 1'b0;
                        end else if (!last_r) begin
                            ctrl_d_r <= 1'b1;
                            state_r  <= S_TX_HOLD;
                        end else if (rx_exp_r == 4'd0) begin
                            tx_ready_r <= 1'b1;
                            busy_r     <= 1'b0;
                            state_r    <= S_IDLE;
                        end else begin
                            ctrl_de_r  <= 1'b0;
                            turn_cnt_r <= '0;
                            rem_r      <= rx_exp_r;
                            state_r    <= S_TURN_RX;
                        end
                    end else begin
                        ctrl_d_r <= frame_bit(tx_bit_r, tx_shreg_r[0]);
                        if (tx_cyc_r == BIT_LAST) begin
                            tx_cyc_r <= 8'd0;
                            tx_bit_r <= tx_bit_r + 4'd1;
                            if (tx_bit_r >= 4'd1 && tx_bit_r <= 4'd8) begin
                                tx_shreg_r <= {1'b1, tx_shreg_r[7:1]};
                            end
                            tx_ready_r <= (tx_bit_r == 4'd9) && !last_r;
                        end else begin
                            tx_cyc_r <= tx_cyc_r + 8'd1;
                        end
                    end
                end
                S_TURN_RX: begin
                    if (turn_cnt_r == TURN_LAST) begin
                        ctrl_ren_r <= 1'b0;
                        tout_cnt_r <= '0;
                        state_r    <= S_RX_WAIT;
                    end else begin
                        turn_cnt_r <= turn_cnt_r + TURN_ONE;
                    end
                end
                S_RX_WAIT: begin
                    if (!sync2_r) begin
                        rx_bit_r <= 4'd0;
                        rx_cyc_r <= 8'd1;
                        state_r  <= S_RX;
                    end else if (tout_cnt_r == TOUT_LAST) begin
                        timeout_r  <= 1'b1;
                        ctrl_ren_r <= 1'b1;
                        turn_cnt_r <= '0;
                        state_r    <= S_TURN_TX;
                    end else begin
                        tout_cnt_r <= tout_cnt_r + TOUT_ONE;
                    end
                end
                S_RX: begin
`ifdef CTRL_LINE_RX_MAJORITY_EN
                    if (rx_cyc_r == MID_M1) s_m1_r <= sync2_r;
`endif
                    if (rx_cyc_r == MID) s_mid_r <= sync2_r;
                    if (rx_cyc_r == BIT_LAST) begin
                        rx_cyc_r <= 8'd0;
                        rx_bit_r <= rx_bit_r + 4'd1;
                    end else begin
                        rx_cyc_r <= rx_cyc_r + 8'd1;
                    end
                    if (rx_cyc_r == MID_P1) begin
                        if (rx_bit_r == 4'd0) begin
                            if (rx_vote_s) state_r <= S_RX_WAIT;
                        end else if (rx_bit_r <= 4'd8) begin
                            rx_shreg_r <= {rx_vote_s, rx_shreg_r[7:1]};
                        end else begin
                            rx_data_r  <= rx_shreg_r;
                            rx_valid_r <= rx_vote_s;
                            rx_err_r   <= !rx_vote_s;
                            rem_r      <= rem_r - 4'd1;
                            if (rem_r == 4'd1) begin
                                ctrl_ren_r <= 1'b1;
                                turn_cnt_r <= '0;
                                state_r    <= S_TURN_TX;
                            end else begin
                                tout_cnt_r <= '0;
                                state_r    <= S_RX_WAIT;
                            end
                        end
                    end
                end
                S_TURN_TX: begin
                    if (turn_cnt_r == TURN_LAST) begin
                        ctrl_de_r  <= 1'b1;
                        ctrl_d_r   <= 1'b1;
                        tx_ready_r <= 1'b1;
                        busy_r     <= 1'b0;
                        state_r    <= S_IDLE;
                    end else begin
                        turn_cnt_r <= turn_cnt_r + TURN_ONE;
                    end
                end
                default: begin
                    ctrl_d_r   <= 1'b1;
                    ctrl_de_r  <= 1'b1;
                    ctrl_ren_r <= 1'b1;
                    tx_ready_r <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_ready = tx_ready_r;
    assign rx_data  = rx_data_r;
    assign rx_valid = rx_valid_r;
    assign rx_err   = rx_err_r;
    assign timeout  = timeout_r;
    assign busy     = busy_r;
    assign ctrl_d   = ctrl_d_r;
    assign ctrl_de  = ctrl_de_r;
    assign ctrl_ren = ctrl_ren_r;

endmodule

// File: tb/tb_ctrl_line_master.sv
// Directed, table-driven bench for ctrl_line_master with default parameters (4/8/1023).
module tb_ctrl_line_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic [3:0] rx_expect;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic       timeout;
    logic       busy;
    logic       ctrl_d;
    logic       ctrl_de;
    logic       ctrl_ren;
    logic       ctrl_r;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int n_err    = 0;
    int n_tout   = 0;
    int inv_bad  = 0;
    logic [7:0] last_rx = 8'd0;

`ifdef CTRL_LINE_RX_MAJORITY_EN
    localparam logic [7:0] GLITCH_EXP = 8'hE1;
`else
    localparam logic [7:0] GLITCH_EXP = 8'hE9;
`endif

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // line bits in time order, bit 0 first
    } tx_vec_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         glitch;  // frame bit index to glitch at its mid cycle, -1 for none
        int         exp_valid;
        int         exp_err;
        logic [7:0] exp_data;
    } rx_vec_t;

    tx_vec_t tx_tab[4];
    rx_vec_t rx_tab[5];

    ctrl_line_master dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_last(tx_last), .rx_expect(rx_expect), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
        .timeout(timeout), .busy(busy), .ctrl_d(ctrl_d), .ctrl_de(ctrl_de),
        .ctrl_ren(ctrl_ren), .ctrl_r(ctrl_r)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            n_valid++;
            last_rx = rx_data;
        end
        if (rx_err === 1'b1) n_err++;
        if (timeout === 1'b1) n_tout++;
        if (rst_n === 1'b1 && ctrl_de === 1'b1 && ctrl_ren === 1'b0) inv_bad++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic probe(input int which);
        case (which)
            0: return ctrl_de;
            1: return ctrl_ren;
            2: return busy;
            default: return tx_ready;
        endcase
    endfunction

    // Ticks until the probed signal has the given value; n = ticks taken or -1 on expiry
    task automatic wait_for(input int which, input logic val, input int limit, output int n);
        n = 0;
        while (probe(which) !== val && n < limit) begin
            tick();
            n++;
        end
        if (probe(which) !== val) n = -1;
    endtask

    task automatic send_idle(input logic [7:0] d, input logic l, input logic [3:0] e);
        int n;
        wait_for(3, 1'b1, 200, n);
        check("ready_wait", 128'(n >= 0), 128'd1);
        tx_data = d; tx_last = l; rx_expect = e; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic capture40(output logic [39:0] obs, output logic de_low);
        de_low = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            obs[k] = ctrl_d;
            if (ctrl_de !== 1'b1) de_low = 1'b1;
        end
    endtask

    function automatic logic [39:0] expand(input logic [9:0] f);
        logic [39:0] x;
        for (int k = 0; k < 40; k++) x[k] = f[k / 4];
        return x;
    endfunction

    task automatic drive_rx(input logic [7:0] d, input logic stop, input int glitch);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < 4; c++) begin
                ctrl_r = (i == glitch && c == 2) ? ~f[i] : f[i];
                tick();
            end
        end
        ctrl_r = 1'b1;
    endtask

    initial begin
        logic [39:0] obs40;
        logic [79:0] obs80, exp80;
        logic [19:0] fr20;
        logic        de_low, bad;
        int          n, v0, e0, t0;

        tx_tab[0] = '{8'hA5, 10'h34A};
        tx_tab[1] = '{8'h00, 10'h200};
        tx_tab[2] = '{8'hFF, 10'h3FE};
        tx_tab[3] = '{8'h3C, 10'h278};
        rx_tab[0] = '{8'h5A, 1'b1, -1, 1, 0, 8'h5A};
        rx_tab[1] = '{8'h77, 1'b0, -1, 0, 1, 8'h77};
        rx_tab[2] = '{8'hE1, 1'b1,  4, 1, 0, GLITCH_EXP};
        rx_tab[3] = '{8'h00, 1'b1, -1, 1, 0, 8'h00};
        rx_tab[4] = '{8'hFF, 1'b1, -1, 1, 0, 8'hFF};

        rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'd0; tx_last = 1'b0;
        rx_expect = 4'd0; ctrl_r = 1'b1;
        #12;
        check("rst_ctrl_d", ctrl_d, 1'b1);
        check("rst_ctrl_de", ctrl_de, 1'b1);
        check("rst_ctrl_ren", ctrl_ren, 1'b1);
        check("rst_tx_ready", tx_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_strobes", {rx_valid, rx_err, timeout}, 3'b000);
        check("rst_rx_data", rx_data, 8'h00);
        #10 rst_n = 1'b1;
        tick();
        check("ready_after_rst", tx_ready, 1'b1);

        // Single-byte commands with no response
        for (int i = 0; i < 4; i++) begin
            send_idle(tx_tab[i].data, 1'b1, 4'd0);
            check("tx_busy_high", busy, 1'b1);
            capture40(obs40, de_low);
            check("tx_frame", obs40, expand(tx_tab[i].frame));
            check("tx_de_held", de_low, 1'b0);
            tick();
            check("tx_busy_low", busy, 1'b0);
            check("tx_ready_idle", tx_ready, 1'b1);
        end

        // Two-byte command back-to-back, one-byte response
        tx_data = 8'h3C; tx_last = 1'b0; rx_expect = 4'd0; tx_valid = 1'b1;
        tick();
        tx_data = 8'h81; tx_last = 1'b1; rx_expect = 4'd1;
        for (int k = 1; k <= 80; k++) begin
            tick();
            obs80[k-1] = ctrl_d;
            if (k == 20) check("b2b_ready_low", tx_ready, 1'b0);
            if (k == 40) check("b2b_ready_high", tx_ready, 1'b1);
            if (k == 41) tx_valid = 1'b0;
        end
        fr20 = {10'h302, 10'h278};
        for (int k = 0; k < 80; k++) exp80[k] = fr20[k / 4];
        check("b2b_frames", obs80, exp80);
        wait_for(0, 1'b0, 20, n);
        check("de_fall_delay", n, 1);
        wait_for(1, 1'b0, 20, n);
        check("ren_fall_delay", n, 8);
        check("de_low_at_ren", ctrl_de, 1'b0);
        v0 = n_valid; e0 = n_err;
        tick(); tick();
        drive_rx(8'h5A, 1'b1, -1);
        wait_for(1, 1'b1, 20, n);
        check("ren_rise_found", 128'(n >= 0), 128'd1);
        wait_for(0, 1'b1, 20, n);
        check("de_rise_delay", n, 8);
        tick();
        check("resp_valid_cnt", n_valid - v0, 1);
        check("resp_err_cnt", n_err - e0, 0);
        check("resp_data", last_rx, 8'h5A);
        check("resp_idle", {busy, ctrl_de, ctrl_ren}, 3'b011);

        // No response: timeout
        v0 = n_valid; t0 = n_tout;
        send_idle(8'h00, 1'b1, 4'd2);
        wait_for(1, 1'b0, 200, n);
        check("to_ren_fall", 128'(n >= 0), 128'd1);
        n = 0;
        while (timeout !== 1'b1 && n < 1100) begin
            tick();
            n++;
        end
        check("timeout_delay", n, 1023);
        wait_for(2, 1'b0, 50, n);
        check("to_idle", 128'(n >= 0), 128'd1);
        check("to_pulse_cnt", n_tout - t0, 1);
        check("to_no_valid", n_valid - v0, 0);
        check("to_de_back", ctrl_de, 1'b1);

        // Response table
        for (int i = 0; i < 5; i++) begin
            v0 = n_valid; e0 = n_err;
            send_idle(8'h11, 1'b1, 4'd1);
            wait_for(1, 1'b0, 200, n);
            check("rx_ren_fall", 128'(n >= 0), 128'd1);
            tick(); tick();
            drive_rx(rx_tab[i].data, rx_tab[i].stop, rx_tab[i].glitch);
            wait_for(2, 1'b0, 60, n);
            check("rx_idle", 128'(n >= 0), 128'd1);
            check("rx_valid_cnt", n_valid - v0, rx_tab[i].exp_valid);
            check("rx_err_cnt", n_err - e0, rx_tab[i].exp_err);
            check("rx_data", rx_data, rx_tab[i].exp_data);
        end

        // Short low glitch while waiting for a response is a false start
        v0 = n_valid; e0 = n_err;
        send_idle(8'h22, 1'b1, 4'd1);
        wait_for(1, 1'b0, 200, n);
        check("gl_ren_fall", 128'(n >= 0), 128'd1);
        repeat (3) tick();
        ctrl_r = 1'b0;
        tick();
        ctrl_r = 1'b1;
        repeat (20) tick();
        check("gl_no_strobe", (n_valid - v0) + (n_err - e0), 0);
        check("gl_still_busy", {busy, ctrl_ren}, 2'b10);
        drive_rx(8'hC3, 1'b1, -1);
        wait_for(2, 1'b0, 60, n);
        check("gl_idle", 128'(n >= 0), 128'd1);
        check("gl_valid_cnt", n_valid - v0, 1);
        check("gl_data", last_rx, 8'hC3);

        // Stalled sender between two bytes
        tx_data = 8'h3C; tx_last = 1'b0; rx_expect = 4'd0; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        capture40(obs40, de_low);
        check("st_frame1", obs40, expand(10'h278));
        tick();
        bad = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (ctrl_d !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b1) bad = 1'b1;
        end
        check("st_hold_line", bad, 1'b0);
        tx_data = 8'h81; tx_last = 1'b1; rx_expect = 4'd0; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        capture40(obs40, de_low);
        check("st_frame2", obs40, expand(10'h302));
        tick();
        check("st_busy_low", busy, 1'b0);

        // Reset in the middle of a frame
        send_idle(8'hA5, 1'b1, 4'd0);
        repeat (10) tick();
        check("mr_line_low", ctrl_d, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("mr_outputs", {ctrl_d, ctrl_de, ctrl_ren, tx_ready, busy}, 5'b11100);
        #10 rst_n = 1'b1;
        tick();
        send_idle(8'h81, 1'b1, 4'd0);
        capture40(obs40, de_low);
        check("mr_frame", obs40, expand(10'h302));
        tick();
        check("mr_busy_low", busy, 1'b0);

        check("de_ren_invariant", inv_bad, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
